// File: rtl/int_pkg.sv
// Shared definitions for the vectored interrupt controller.
// Provides the FSM state type, register offsets and the default vector base.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        IN_SERVICE
    } state_t;

    localparam logic [1:0] INT_MASK = 2'd0;
    localparam logic [1:0] INT_PEND = 2'd1;
    localparam logic [1:0] INT_STAT = 2'd2;

    localparam logic [31:0] DEF_VEC_BASE = 32'h0000_0100;

endpackage

// File: rtl/int_ctrl_if.sv
// Memory-mapped register bus of the interrupt controller.
// Ports: we (write enable), addr (register select), wd (write data),
// rd (combinational read data). master = CPU side, slave = controller.
interface int_ctrl_if;

    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (
        output we,
        output addr,
        output wd,
        input  rd
    );

    modport slave (
        input  we,
        input  addr,
        input  wd,
        output rd
    );

endinterface

// File: rtl/int_prio_enc.sv
// Combinational lowest-index priority encoder.
// Ports: req (request bits), valid (any request), id (lowest set index).
module int_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   id
);

    // Scan from the top down so the lowest set index is the last to win.
    always_comb begin
        valid = |req;
        id    = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge-latched sources, software mask,
// lowest-index dispatch, one handler in service until eret.
// Ports: clk, rst (async high), int_src (request lines), eret (return
// strobe), bus (register slave), irq (dispatch pulse), EAddr (vector).
module int_ctrl
    import int_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] VEC_BASE  = DEF_VEC_BASE,
    parameter int          VEC_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] int_src,
    input  logic             eret,
    int_ctrl_if.slave        bus,
    output logic             irq,
    output logic [31:0]      EAddr
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] cand_req;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cur_id_q;
    logic [2:0] cur_id_d;

    logic       cand_valid;
    logic [2:0] cand_id;
    logic       pend_wr;
    logic       mask_wr;
    logic       in_service;
    logic       unused_wd;

    assign rise     = int_src & ~src_q;
    assign cand_req = pending & mask;
    assign pend_wr  = bus.we && (bus.addr == INT_PEND);
    assign mask_wr  = bus.we && (bus.addr == INT_MASK);
    assign unused_wd = ^bus.wd;

    int_prio_enc #(
        .N (N_SRC)
    ) u_enc (
        .req   (cand_req),
        .valid (cand_valid),
        .id    (cand_id)
    );

    // Clear sources: software W1C and the source being dispatched.
    always_comb begin
        clr = '0;
        if (pend_wr) begin
            clr = bus.wd[N_SRC-1:0];
        end
        if (state_q == DISPATCH) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (cur_id_q == 3'(i)) begin
                    clr[i] = 1'b1;
                end
            end
        end
    end

    // A new rise wins over any clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            src_q   <= int_src;
            pending <= (pending & ~clr) | rise;
            if (mask_wr) begin
                mask <= bus.wd[N_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_id_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        unique case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    state_d  = DISPATCH;
                    cur_id_d = cand_id;
                end
            end
            DISPATCH: begin
                state_d = IN_SERVICE;
            end
            IN_SERVICE: begin
                if (eret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign irq        = (state_q == DISPATCH);
    assign in_service = (state_q != IDLE);

    // cur_id only changes on dispatch, so the vector holds between dispatches.
    assign EAddr = VEC_BASE + (32'(cur_id_q) << VEC_SHIFT);

    always_comb begin
        bus.rd = 32'd0;
        case (bus.addr)
            INT_MASK: bus.rd = 32'(mask);
            INT_PEND: bus.rd = 32'(pending);
            INT_STAT: bus.rd = {23'd0, in_service, 5'd0, cur_id_q};
            default:  bus.rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
// Drives the register bus and source lines, checks irq/EAddr/registers.
module tb_int_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] int_src;
    logic       eret;
    logic       irq;
    logic [31:0] EAddr;

    int checks;
    int errors;
    int irq_cnt;
    int dbl_cnt;
    logic prev_irq;
    logic [31:0] rdv;

    int_ctrl_if bus ();

    int_ctrl #(
        .N_SRC     (4),
        .VEC_BASE  (32'h0000_0100),
        .VEC_SHIFT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .int_src (int_src),
        .eret    (eret),
        .bus     (bus),
        .irq     (irq),
        .EAddr   (EAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq) irq_cnt++;
        if (irq && prev_irq) dbl_cnt++;
        prev_irq = irq;
    end

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [31:0] exp);
        bus.addr = a;
        #1;
        rdv = bus.rd;
        chk(tag, rdv, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = d;
        tick();
        bus.we   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        irq_cnt  = 0;
        dbl_cnt  = 0;
        prev_irq = 1'b0;
        rst      = 1'b1;
        int_src  = 4'b0;
        eret     = 1'b0;
        bus.we   = 1'b0;
        bus.addr = 2'd0;
        bus.wd   = 32'd0;
        tick();
        tick();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_eaddr", EAddr, 32'h100);
        rd_chk("rst_mask", 2'd0, 32'd0);
        rd_chk("rst_pend", 2'd1, 32'd0);
        rd_chk("rst_stat", 2'd2, 32'd0);
        rd_chk("rst_resv", 2'd3, 32'd0);
        rst = 1'b0;
        tick();

        // Masked source latches but never dispatches.
        int_src = 4'b0100;
        tick();
        int_src = 4'b0000;
        tick();
        tick();
        tick();
        rd_chk("masked_pend", 2'd1, 32'h4);
        chk("masked_noirq", 32'(irq_cnt), 32'd0);
        wr(2'd1, 32'h4);
        rd_chk("w1c_pend2", 2'd1, 32'd0);

        // Register write filtering.
        wr(2'd0, 32'hFFFF_FFFF);
        rd_chk("mask_rb", 2'd0, 32'hF);
        wr(2'd2, 32'hFFFF_FFFF);
        rd_chk("stat_wr_ign", 2'd2, 32'd0);
        rd_chk("resv_rd", 2'd3, 32'd0);

        // Single dispatch of source 1 with exact latency.
        int_src = 4'b0010;
        tick();
        int_src = 4'b0000;
        chk("s1_t1_irq", 32'(irq), 32'd0);
        tick();
        chk("s1_t2_irq", 32'(irq), 32'd1);
        chk("s1_eaddr", EAddr, 32'h110);
        tick();
        chk("s1_t3_irq", 32'(irq), 32'd0);
        rd_chk("s1_pend", 2'd1, 32'd0);
        rd_chk("s1_stat", 2'd2, 32'h101);
        chk("s1_eaddr_hold", EAddr, 32'h110);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd_chk("s1_idle_stat", 2'd2, 32'h001);

        // Simultaneous rises: lowest index first, then the other.
        int_src = 4'b1001;
        tick();
        int_src = 4'b0000;
        tick();
        chk("s0_irq", 32'(irq), 32'd1);
        chk("s0_eaddr", EAddr, 32'h100);
        tick();
        rd_chk("s0_pend", 2'd1, 32'h8);
        tick();
        chk("s0_hold_irq", 32'(irq), 32'd0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("s3_t1_irq", 32'(irq), 32'd0);
        tick();
        chk("s3_irq", 32'(irq), 32'd1);
        chk("s3_eaddr", EAddr, 32'h130);
        tick();
        chk("s3_t3_irq", 32'(irq), 32'd0);

        // Rise during service waits for eret.
        int_src = 4'b0100;
        tick();
        int_src = 4'b0000;
        tick();
        tick();
        tick();
        chk("nest_cnt", 32'(irq_cnt), 32'd3);
        rd_chk("nest_pend", 2'd1, 32'h4);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("s2_t1_irq", 32'(irq), 32'd0);
        tick();
        chk("s2_irq", 32'(irq), 32'd1);
        chk("s2_eaddr", EAddr, 32'h120);
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // Set beats W1C; W1C alone clears without dispatch.
        wr(2'd0, 32'h0);
        int_src = 4'b0010;
        tick();
        int_src = 4'b0000;
        tick();
        int_src  = 4'b0010;
        bus.we   = 1'b1;
        bus.addr = 2'd1;
        bus.wd   = 32'h2;
        tick();
        bus.we   = 1'b0;
        int_src  = 4'b0000;
        rd_chk("setwin_pend", 2'd1, 32'h2);
        wr(2'd1, 32'h2);
        rd_chk("w1c_pend1", 2'd1, 32'd0);
        wr(2'd0, 32'hF);
        tick();
        tick();
        tick();
        chk("w1c_nodisp", 32'(irq_cnt), 32'd4);

        // Reset in service abandons the handler.
        int_src = 4'b0001;
        tick();
        int_src = 4'b0000;
        tick();
        tick();
        rd_chk("svc_stat", 2'd2, 32'h100);
        rst = 1'b1;
        #1;
        chk("rst_svc_irq", 32'(irq), 32'd0);
        rd_chk("rst_svc_stat", 2'd2, 32'd0);
        rd_chk("rst_svc_mask", 2'd0, 32'd0);
        tick();
        rst = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        tick();
        tick();
        rd_chk("post_rst_stat", 2'd2, 32'd0);
        chk("post_rst_eaddr", EAddr, 32'h100);
        chk("irq_total", 32'(irq_cnt), 32'd5);
        chk("irq_no_double", 32'(dbl_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Vectored interrupt controller directly upstream of the single-cycle MIPS datapath: it produces the `irq` pulse and the exception vector `EAddr`, and consumes the decoded return-from-interrupt strobe. It latches rising edges from up to `N_SRC` peripheral lines, applies a software mask, selects the lowest-numbered enabled pending source and holds off further dispatch until the handler returns. Mask and pending state are exposed as memory-mapped registers.

## Interface
- `N_SRC`, 4: number of interrupt source lines (1..8).
- `VEC_BASE`, 32'h0000_0100: vector of source 0.
- `VEC_SHIFT`, 4: vector spacing is 2^`VEC_SHIFT` bytes per source.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `int_src`  in  N_SRC  peripheral request lines, synchronous to `clk`; rising edge requests.
- `eret`  in  1  return strobe from control unit; same cycle the datapath selects saved EPC.
- `we`  in  1  register write enable.
- `addr`  in  2  register select: 0 MASK, 1 PENDING, 2 STATUS, 3 reserved.
- `wd`  in  32  write data.
- `rd`  out  32  read data, combinational from `addr`.
- `irq`  out  1  dispatch pulse to datapath (EPC capture and vector select).
- `EAddr`  out  32  vector address, valid while `irq`=1.

## Operation
- Edge detect: `src_q` registers `int_src`; rise[i] = `int_src`[i] & ~`src_q`[i]. `src_q` resets to 0, so a line high out of reset requests once.
- `pending`[i] set on rise[i]; cleared on dispatch of source i or by writing 1 to PENDING bit i. Set beats clear in the same cycle. A rise while already pending is absorbed (one bit, no count).
- MASK[N_SRC-1:0] read/write, reset 0 (all disabled); upper bits read 0, writes ignored.
- Candidate = lowest i with `pending`[i] & MASK[i].
- FSM:
  - IDLE: if a candidate exists → DISPATCH, registering `cur_id` = candidate.
  - DISPATCH (exactly one cycle): `irq`=1, `EAddr` = VEC_BASE + (`cur_id` << VEC_SHIFT); `pending`[`cur_id`] cleared at end of cycle; → IN_SERVICE.
  - IN_SERVICE: `eret`=1 → IDLE; otherwise stay. No nesting.
- `eret` in IDLE or DISPATCH is ignored.
- Masking a source already in DISPATCH/IN_SERVICE does not abort it.
- Registers: PENDING read = `pending` (zero-extended); write = write-1-to-clear. STATUS read = {23'b0, in_service, 5'b0, cur_id[2:0]}, `in_service` = state≠IDLE. Writes to STATUS/reserved ignored; reserved reads 0.

## Timing
- Reset: state IDLE, `irq`=0, `EAddr`=VEC_BASE, `pending`=0, MASK=0, `cur_id`=0, `src_q`=0; `rd` follows `addr` (all zero except MASK/PENDING/STATUS contents, which are 0). Reset mid-service abandons the handler with no further `irq`.
- Latency: rise in cycle t → `pending` visible t+1 → DISPATCH (`irq`=1) in t+2 if enabled and IDLE.
- `irq` is a registered-state decode, high exactly one cycle per dispatch, never two consecutive cycles.
- After `eret` in cycle t, state is IDLE at t+1; earliest next `irq` is t+2.
- MASK write in cycle t affects candidate selection from t+1.
- `EAddr` holds its last vector outside DISPATCH; the datapath only uses it while `irq`=1.

## Structure
- Shared package `int_pkg`: FSM state enum (IDLE, DISPATCH, IN_SERVICE), register offsets `INT_MASK`=0, `INT_PEND`=1, `INT_STAT`=2, default VEC_BASE.
- One sub-module `int_prio_enc`: combinational lowest-index priority encoder (N_SRC request bits → valid + 3-bit id).

## Test plan
- Reset, MASK=4'b0000, pulse `int_src`[2] → PENDING reads 4'b0100, `irq` never asserts.
- MASK=4'b1111, rise on src 1 at t → `irq`=1 exactly at t+2, `EAddr`=32'h0000_0110, PENDING bit 1 clear at t+3, STATUS=32'h0000_0101.
- Rises on src 3 and src 0 same cycle → dispatch src 0 (`EAddr`=32'h100); after `eret`, src 3 dispatches two cycles later (`EAddr`=32'h130).
- Rise on src 2 during IN_SERVICE → no `irq` until `eret`; `eret` at t → `irq` at t+2 with `EAddr`=32'h120.
- W1C PENDING bit 1 in the same cycle as a new rise on src 1 → bit stays set; W1C alone clears it and no dispatch occurs.
- Assert `rst` during IN_SERVICE → `irq`=0, STATUS=0, MASK=0 immediately; `eret` afterwards has no effect.
